input_vc_controller: RTL

- Per-input-VC front end of the router pipeline.
- Buffers incoming flits in a FIFO and issues a one-cycle rc_req to routing_computation for each head flit.
- Latches the returned outport_vec/allow_vcs, requests a downstream VC from the VC allocator, then presents flits to the switch allocator until the tail flit leaves.
- One instance per input VC per port.

---
 rtl/router_pkg.sv | 28 ++
 rtl/ivc_fifo.sv | 62 ++++++
 rtl/input_vc_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: flit type encodings, input-VC state encoding, flit type helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package router_pkg;

    localparam logic [1:0] FLIT_BODY     = 2'b00;
    localparam logic [1:0] FLIT_HEAD     = 2'b01;
    localparam logic [1:0] FLIT_TAIL     = 2'b10;
    localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RC      = 3'd1,
        RC_WAIT = 3'd2,
        VA      = 3'd3,
        ACTIVE  = 3'd4
    } ivc_state_t;

    // A head+tail flit both opens and closes a packet.
    function automatic logic is_head(input logic [1:0] flit_type);
        return (flit_type == FLIT_HEAD) || (flit_type == FLIT_HEADTAIL);
    endfunction

    function automatic logic is_tail(input logic [1:0] flit_type);
        return (flit_type == FLIT_TAIL) || (flit_type == FLIT_HEADTAIL);
    endfunction

endpackage

// File: rtl/ivc_fifo.sv
// Synchronous FIFO with full/empty flags and simultaneous read/write; front entry shown combinationally.
// Latency: a write is visible at rd_dat the cycle after it is accepted (when the FIFO was empty).
// Backpressure: writes while full are dropped unless a read happens in the same cycle; reads while empty are ignored.
// Ports: clk, reset (sync, active-high), wr_en/wr_dat, rd_en/rd_dat, empty, full.
module ivc_fifo #(
    parameter int width = 18,
    parameter int depth = 4,
    parameter int cnt_w = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_dat,
    input  logic             rd_en,
    output logic [width-1:0] rd_dat,
    output logic             empty,
    output logic             full
);

    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0] mem [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             do_rd;
    logic             do_wr;

    assign empty = (count == '0);
    assign full  = (count == cnt_w'(depth));

    // A full FIFO still accepts a write when the front entry leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + ptr_w'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_vc_controller.sv
// Per-input-VC front end: buffers flits, runs route computation, VC allocation, then feeds the switch allocator.
// Latency: head into empty FIFO -> first possible sw_req after IDLE, RC, RC_WAIT and VA (same-cycle grant); credit_out one cycle after dequeue.
// Backpressure: sw_req held off by credit_ok; writes to a full FIFO without a same-cycle dequeue are dropped.
// Ports: flit_in/flit_in_type/flit_in_valid in; credit_out upstream; rc_* to routing; va_* to VC allocator;
//        sw_req/sw_grant/credit_ok to switch allocator; flit_out/flit_out_type/out_vc to crossbar; buf_empty/buf_full status.
// Optional: define IVC_PROTOCOL_CHECK_EN to add the sticky proto_err output and its protocol checks.
module input_vc_controller
    import router_pkg::*;
#(
    parameter int flit_size                   = 1,
    parameter int phit_size                   = 16,
    parameter int no_outport                  = 6,
    parameter int no_vc                       = 13,
    parameter int floorplusone_log2_no_vc     = 4,
    parameter int buf_depth                   = 4,
    parameter int floorplusone_log2_buf_depth = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [flit_size*phit_size-1:0]     flit_in,
    input  logic [1:0]                         flit_in_type,
    input  logic                               flit_in_valid,
    output logic                               credit_out,
    output logic                               rc_req,
    output logic [flit_size*phit_size-1:0]     rc_header,
    input  logic                               rc_valid,
    input  logic [no_outport-1:0]              outport_vec,
    input  logic [no_vc-1:0]                   allow_vcs,
    output logic                               va_req,
    output logic [no_outport-1:0]              va_outport_vec,
    output logic [no_vc-1:0]                   va_allow_vcs,
    input  logic                               va_grant,
    input  logic [floorplusone_log2_no_vc-1:0] va_vc,
    input  logic                               credit_ok,
    output logic                               sw_req,
    input  logic                               sw_grant,
    output logic [flit_size*phit_size-1:0]     flit_out,
    output logic [1:0]                         flit_out_type,
    output logic [floorplusone_log2_no_vc-1:0] out_vc,
    output logic                               buf_empty,
    output logic                               buf_full
`ifdef IVC_PROTOCOL_CHECK_EN
    ,
    output logic                               proto_err
`endif
);

    localparam int fw = flit_size * phit_size;

    ivc_state_t    state;
    ivc_state_t    next_state;
    logic [fw+1:0] fifo_rd_dat;
    logic [fw-1:0] front_flit;
    logic [1:0]    front_type;
    logic          discard;
    logic          deq_active;
    logic          deq;

    assign {front_type, front_flit} = fifo_rd_dat;

    assign flit_out      = front_flit;
    assign flit_out_type = front_type;
    assign rc_header     = front_flit;

    assign deq = discard || deq_active;

    ivc_fifo #(
        .width (fw + 2),
        .depth (buf_depth),
        .cnt_w (floorplusone_log2_buf_depth)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (flit_in_valid),
        .wr_dat ({flit_in_type, flit_in}),
        .rd_en  (deq),
        .rd_dat (fifo_rd_dat),
        .empty  (buf_empty),
        .full   (buf_full)
    );

    // The head flit stays in the FIFO through RC/VA and is the first flit sent in ACTIVE.
    always_comb begin
        next_state = state;
        rc_req     = 1'b0;
        va_req     = 1'b0;
        sw_req     = 1'b0;
        discard    = 1'b0;
        deq_active = 1'b0;
        case (state)
            IDLE: begin
                if (!buf_empty) begin
                    if (is_head(front_type)) begin
                        next_state = RC;
                    end else begin
                        // Stray body/tail with no packet context: drop it but still return its credit.
                        discard = 1'b1;
                    end
                end
            end
            RC: begin
                rc_req     = 1'b1;
                next_state = RC_WAIT;
            end
            RC_WAIT: begin
                if (rc_valid) begin
                    next_state = VA;
                end
            end
            VA: begin
                va_req = 1'b1;
                if (va_grant) begin
                    next_state = ACTIVE;
                end
            end
            ACTIVE: begin
                sw_req     = !buf_empty && credit_ok;
                deq_active = sw_req && sw_grant;
                if (deq_active && is_tail(front_type)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            credit_out     <= 1'b0;
            va_outport_vec <= '0;
            va_allow_vcs   <= '0;
            out_vc         <= '0;
        end else begin
            state      <= next_state;
            credit_out <= deq;
            if ((state == RC_WAIT) && rc_valid) begin
                va_outport_vec <= outport_vec;
                va_allow_vcs   <= allow_vcs;
            end
            if ((state == VA) && va_grant) begin
                out_vc <= va_vc;
            end
        end
    end

`ifdef IVC_PROTOCOL_CHECK_EN
    // first_sent separates the packet's own head (legal first dequeue) from a stray head mid-packet.
    logic first_sent;
    logic err_now;

    always_comb begin
        err_now = 1'b0;
        if (flit_in_valid && buf_full && !deq)                  err_now = 1'b1;
        if (discard)                                             err_now = 1'b1;
        if (deq_active && is_head(front_type) && first_sent)     err_now = 1'b1;
        if ((state == RC_WAIT) && !rc_valid)                     err_now = 1'b1;
        if (rc_valid && !$onehot(outport_vec))                   err_now = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            first_sent <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (state == VA) begin
                first_sent <= 1'b0;
            end else if (deq_active) begin
                first_sent <= 1'b1;
            end
            proto_err <= proto_err | err_now;
        end
    end
`endif

endmodule
